binary_dispatcher: RTL and testbench

//   Return-path counterpart of binary_aggregator: takes one keyed item per cycle
//   and delivers it to one of CANDIDATE_CNT destinations (or all, on broadcast).

---
 rtl/binary_dispatcher_pkg.sv | 16 +
 rtl/binary_dispatcher_slot.sv | 45 ++++
 rtl/binary_dispatcher.sv | 115 +++++++++++
 tb/tb_binary_dispatcher.sv | 331 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/binary_dispatcher_pkg.sv
// Shared defaults and helpers for the dispatcher return path; the default widths
// match those of binary_aggregator so the two blocks line up without overrides.
package binary_dispatcher_pkg;

    localparam int DEF_CANDIDATE_CNT = 5;
    localparam int DEF_KEY_WIDTH     = 6;
    localparam int DEF_DATA_WIDTH    = 16;
    localparam int DEF_DEST_WIDTH    = 3;
    localparam int DEF_CNT_WIDTH     = 8;

    // A slot can take a new item when empty or when being drained this cycle.
    function automatic logic slot_free(input logic vld, input logic rdy);
        return (!vld) || rdy;
    endfunction

endpackage

// File: rtl/binary_dispatcher_slot.sv
// One-entry registered output slot with valid/ready handshake; contents stay
// stable while valid and not drained, and a drain and refill may share a cycle.
module dispatcher_slot
    import binary_dispatcher_pkg::*;
#(
    parameter int KEY_WIDTH  = DEF_KEY_WIDTH,
    parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  wr_en,
    input  logic [KEY_WIDTH-1:0]  wr_key,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  out_rdy,
    output logic                  out_vld,
    output logic [KEY_WIDTH-1:0]  out_key,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  free
);

    logic                  vld_r;
    logic [KEY_WIDTH-1:0]  key_r;
    logic [DATA_WIDTH-1:0] data_r;

    // Slot occupancy and payload; a write wins over a drain so the slot stays valid.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_r  <= 1'b0;
            key_r  <= '0;
            data_r <= '0;
        end else if (wr_en) begin
            vld_r  <= 1'b1;
            key_r  <= wr_key;
            data_r <= wr_data;
        end else if (vld_r && out_rdy) begin
            vld_r  <= 1'b0;
        end
    end

    assign out_vld  = vld_r;
    assign out_key  = key_r;
    assign out_data = data_r;
    assign free     = slot_free(vld_r, out_rdy);

endmodule

// File: rtl/binary_dispatcher.sv
// Routes one keyed item per cycle to a single destination slot or to all slots
// on broadcast; items with an out-of-range destination are consumed and counted.
module binary_dispatcher
    import binary_dispatcher_pkg::*;
#(
    parameter int CANDIDATE_CNT = DEF_CANDIDATE_CNT,
    parameter int KEY_WIDTH     = DEF_KEY_WIDTH,
    parameter int DATA_WIDTH    = DEF_DATA_WIDTH,
    parameter int DEST_WIDTH    = DEF_DEST_WIDTH,
    parameter int CNT_WIDTH     = DEF_CNT_WIDTH
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            in_vld,
    output logic                            in_rdy,
    input  logic                            in_bcast,
    input  logic [DEST_WIDTH-1:0]           in_dest,
    input  logic [KEY_WIDTH-1:0]            in_key,
    input  logic [DATA_WIDTH-1:0]           in_data,
    output logic [CANDIDATE_CNT-1:0]        out_vld,
    input  logic [CANDIDATE_CNT-1:0]        out_rdy,
    output logic [CANDIDATE_CNT*KEY_WIDTH-1:0]  out_key,
    output logic [CANDIDATE_CNT*DATA_WIDTH-1:0] out_data,
    output logic                            drop_pulse,
    output logic [CNT_WIDTH-1:0]            drop_cnt
);

    logic [CANDIDATE_CNT-1:0] dest_hot_s;
    logic [CANDIDATE_CNT-1:0] free_s;
    logic [CANDIDATE_CNT-1:0] wr_en_s;
    logic                     dest_ok_s;
    logic                     rdy_s;
    logic                     drop_s;
    logic                     drop_pulse_r;
    logic [CNT_WIDTH-1:0]     drop_cnt_r;

    // Destination index to one-hot; an out-of-range index yields all zeros.
    always_comb begin
        dest_hot_s = '0;
        for (int i = 0; i < CANDIDATE_CNT; i++) begin
            if (in_dest == DEST_WIDTH'(i)) begin
                dest_hot_s[i] = 1'b1;
            end else begin
                dest_hot_s[i] = 1'b0;
            end
        end
    end

    assign dest_ok_s = |dest_hot_s;

    // Ready and write-enable decode; ready never looks at in_vld.
    always_comb begin
        rdy_s   = 1'b1;
        wr_en_s = '0;
        drop_s  = 1'b0;
        if (in_bcast) begin
            rdy_s = &free_s;
            if (in_vld && rdy_s) begin
                wr_en_s = '1;
            end else begin
                wr_en_s = '0;
            end
        end else if (dest_ok_s) begin
            rdy_s = |(dest_hot_s & free_s);
            if (in_vld && rdy_s) begin
                wr_en_s = dest_hot_s;
            end else begin
                wr_en_s = '0;
            end
        end else begin
            rdy_s  = 1'b1;
            drop_s = in_vld;
        end
    end

    assign in_rdy = rdy_s;

    genvar g;
    generate
        for (g = 0; g < CANDIDATE_CNT; g++) begin : g_slot
            dispatcher_slot #(
                .KEY_WIDTH  (KEY_WIDTH),
                .DATA_WIDTH (DATA_WIDTH)
            ) u_slot (
                .clk      (clk),
                .rst_n    (rst_n),
                .wr_en    (wr_en_s[g]),
                .wr_key   (in_key),
                .wr_data  (in_data),
                .out_rdy  (out_rdy[g]),
                .out_vld  (out_vld[g]),
                .out_key  (out_key[g*KEY_WIDTH +: KEY_WIDTH]),
                .out_data (out_data[g*DATA_WIDTH +: DATA_WIDTH]),
                .free     (free_s[g])
            );
        end
    endgenerate

    // Drop pulse and saturating drop counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            drop_pulse_r <= 1'b0;
            drop_cnt_r   <= '0;
        end else begin
            drop_pulse_r <= drop_s;
            if (drop_s && (drop_cnt_r != {CNT_WIDTH{1'b1}})) begin
                drop_cnt_r <= drop_cnt_r + CNT_WIDTH'(1);
            end
        end
    end

    assign drop_pulse = drop_pulse_r;
    assign drop_cnt   = drop_cnt_r;

endmodule

// File: tb/tb_binary_dispatcher.sv
// Self-checking bench for binary_dispatcher: directed scenarios plus a
// per-slot scoreboard fed at acceptance and checked at every drain.
module tb_binary_dispatcher;

    localparam int N  = 5;
    localparam int KW = 6;
    localparam int DW = 16;

    logic            clk;
    logic            rst_n;
    logic            in_vld;
    logic            in_rdy;
    logic            in_bcast;
    logic [2:0]      in_dest;
    logic [KW-1:0]   in_key;
    logic [DW-1:0]   in_data;
    logic [N-1:0]    out_vld;
    logic [N-1:0]    out_rdy;
    logic [N*KW-1:0] out_key;
    logic [N*DW-1:0] out_data;
    logic            drop_pulse;
    logic [7:0]      drop_cnt;

    logic            in_vld2;
    logic            in_rdy2;
    logic [N-1:0]    out_vld2;
    logic [N*KW-1:0] out_key2;
    logic [N*DW-1:0] out_data2;
    logic            drop_pulse2;
    logic [1:0]      drop_cnt2;

    int pass_cnt = 0;
    int chk_cnt  = 0;

    logic [KW+DW-1:0] sb_q [N][$];
    logic             mon_en  = 1'b0;
    logic             mon_acc = 1'b0;
    logic             exp_drop_pulse = 1'b0;
    logic [7:0]       exp_drop_cnt   = 8'd0;

    binary_dispatcher #(.CANDIDATE_CNT(5), .KEY_WIDTH(6), .DATA_WIDTH(16),
                        .DEST_WIDTH(3), .CNT_WIDTH(8)) u_dut (
        .clk(clk), .rst_n(rst_n), .in_vld(in_vld), .in_rdy(in_rdy),
        .in_bcast(in_bcast), .in_dest(in_dest), .in_key(in_key), .in_data(in_data),
        .out_vld(out_vld), .out_rdy(out_rdy), .out_key(out_key), .out_data(out_data),
        .drop_pulse(drop_pulse), .drop_cnt(drop_cnt)
    );

    binary_dispatcher #(.CANDIDATE_CNT(5), .KEY_WIDTH(6), .DATA_WIDTH(16),
                        .DEST_WIDTH(3), .CNT_WIDTH(2)) u_dut_sat (
        .clk(clk), .rst_n(rst_n), .in_vld(in_vld2), .in_rdy(in_rdy2),
        .in_bcast(1'b0), .in_dest(3'd7), .in_key(6'd0), .in_data(16'd0),
        .out_vld(out_vld2), .out_rdy(5'b11111), .out_key(out_key2), .out_data(out_data2),
        .drop_pulse(drop_pulse2), .drop_cnt(drop_cnt2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic vld, input logic bc, input logic [2:0] d,
                         input logic [KW-1:0] k, input logic [DW-1:0] dat);
        in_vld = vld; in_bcast = bc; in_dest = d; in_key = k; in_data = dat;
    endtask

    // Scoreboard monitor: inputs and outputs are stable at the falling edge.
    always @(negedge clk) begin
        if (mon_en) begin
            logic [N-1:0] free_m;
            logic         rdy_m;
            logic         exp_v;
            for (int i = 0; i < N; i++) begin
                exp_v = (sb_q[i].size() != 0);
                chk_cnt++;
                if (out_vld[i] !== exp_v) $display("FAIL mon_vld[%0d]: got %b expected %b", i, out_vld[i], exp_v);
                else pass_cnt++;
                if (exp_v) begin
                    chk_cnt++;
                    if ({out_key[i*KW +: KW], out_data[i*DW +: DW]} !== sb_q[i][0])
                        $display("FAIL mon_payload[%0d]: got %h expected %h", i,
                                 {out_key[i*KW +: KW], out_data[i*DW +: DW]}, sb_q[i][0]);
                    else pass_cnt++;
                end
                free_m[i] = (!exp_v) || out_rdy[i];
            end
            chk_cnt++;
            if (drop_pulse !== exp_drop_pulse) $display("FAIL mon_drop_pulse: got %b expected %b", drop_pulse, exp_drop_pulse);
            else pass_cnt++;
            chk_cnt++;
            if (drop_cnt !== exp_drop_cnt) $display("FAIL mon_drop_cnt: got %0d expected %0d", drop_cnt, exp_drop_cnt);
            else pass_cnt++;
            if (in_bcast) rdy_m = &free_m;
            else if (in_dest < 3'd5) rdy_m = free_m[in_dest];
            else rdy_m = 1'b1;
            chk_cnt++;
            if (in_rdy !== rdy_m) $display("FAIL mon_in_rdy: got %b expected %b", in_rdy, rdy_m);
            else pass_cnt++;
            mon_acc = in_vld && rdy_m;
            for (int i = 0; i < N; i++) begin
                if (sb_q[i].size() != 0 && out_rdy[i]) void'(sb_q[i].pop_front());
            end
            exp_drop_pulse = 1'b0;
            if (mon_acc) begin
                if (in_bcast) begin
                    for (int i = 0; i < N; i++) sb_q[i].push_back({in_key, in_data});
                end else if (in_dest < 3'd5) begin
                    sb_q[in_dest].push_back({in_key, in_data});
                end else begin
                    exp_drop_pulse = 1'b1;
                    if (exp_drop_cnt != 8'hFF) exp_drop_cnt = exp_drop_cnt + 8'd1;
                end
            end
        end
    end

    task automatic test_reset();
        chk_cnt++;
        if (out_vld !== 5'b0 || drop_pulse !== 1'b0 || drop_cnt !== 8'd0)
            $display("FAIL reset_ctrl: got vld=%b pulse=%b cnt=%0d expected 0/0/0", out_vld, drop_pulse, drop_cnt);
        else pass_cnt++;
        chk_cnt++;
        if (out_key !== '0 || out_data !== '0)
            $display("FAIL reset_payload: got key=%h data=%h expected 0", out_key, out_data);
        else pass_cnt++;
    endtask

    task automatic test_unicast();
        out_rdy = 5'b11111;
        drive(1'b1, 1'b0, 3'd2, 6'h15, 16'hBEEF);
        tick();
        drive(1'b0, 1'b0, 3'd0, 6'h00, 16'h0000);
        chk_cnt++;
        if (out_vld !== 5'b00100) $display("FAIL uni_vld: got %b expected 00100", out_vld);
        else pass_cnt++;
        chk_cnt++;
        if (out_key[2*KW +: KW] !== 6'h15 || out_data[2*DW +: DW] !== 16'hBEEF)
            $display("FAIL uni_payload: got %h/%h expected 15/beef", out_key[2*KW +: KW], out_data[2*DW +: DW]);
        else pass_cnt++;
        tick();
        chk_cnt++;
        if (out_vld !== 5'b00000) $display("FAIL uni_clear: got %b expected 00000", out_vld);
        else pass_cnt++;
    endtask

    task automatic test_backpressure();
        out_rdy = 5'b10111;
        drive(1'b1, 1'b0, 3'd3, 6'h01, 16'hA001);
        tick();
        drive(1'b1, 1'b0, 3'd3, 6'h02, 16'hA002);
        for (int c = 0; c < 3; c++) begin
            #1;
            chk_cnt++;
            if (in_rdy !== 1'b0) $display("FAIL bp_rdy_low: got %b expected 0", in_rdy);
            else pass_cnt++;
            chk_cnt++;
            if (out_data[3*DW +: DW] !== 16'hA001) $display("FAIL bp_hold: got %h expected a001", out_data[3*DW +: DW]);
            else pass_cnt++;
            tick();
        end
        out_rdy = 5'b11111;
        #1;
        chk_cnt++;
        if (in_rdy !== 1'b1) $display("FAIL bp_rdy_high: got %b expected 1", in_rdy);
        else pass_cnt++;
        tick();
        drive(1'b0, 1'b0, 3'd0, 6'h00, 16'h0000);
        chk_cnt++;
        if (out_vld[3] !== 1'b1 || out_data[3*DW +: DW] !== 16'hA002)
            $display("FAIL bp_second: got %b/%h expected 1/a002", out_vld[3], out_data[3*DW +: DW]);
        else pass_cnt++;
        tick();
    endtask

    task automatic test_broadcast();
        out_rdy = 5'b11101;
        drive(1'b1, 1'b0, 3'd1, 6'h01, 16'h1111);
        tick();
        drive(1'b1, 1'b1, 3'd0, 6'h3C, 16'h1234);
        #1;
        chk_cnt++;
        if (in_rdy !== 1'b0) $display("FAIL bc_blocked: got %b expected 0", in_rdy);
        else pass_cnt++;
        tick();
        chk_cnt++;
        if (out_vld !== 5'b00010 || out_data[1*DW +: DW] !== 16'h1111)
            $display("FAIL bc_none: got %b/%h expected 00010/1111", out_vld, out_data[1*DW +: DW]);
        else pass_cnt++;
        out_rdy = 5'b11111;
        #1;
        chk_cnt++;
        if (in_rdy !== 1'b1) $display("FAIL bc_open: got %b expected 1", in_rdy);
        else pass_cnt++;
        tick();
        drive(1'b0, 1'b0, 3'd0, 6'h00, 16'h0000);
        chk_cnt++;
        if (out_vld !== 5'b11111) $display("FAIL bc_all_vld: got %b expected 11111", out_vld);
        else pass_cnt++;
        for (int i = 0; i < N; i++) begin
            chk_cnt++;
            if (out_data[i*DW +: DW] !== 16'h1234) $display("FAIL bc_data[%0d]: got %h expected 1234", i, out_data[i*DW +: DW]);
            else pass_cnt++;
        end
        tick();
    endtask

    task automatic test_bad_dest();
        out_rdy = 5'b11111;
        drive(1'b1, 1'b0, 3'd7, 6'h2A, 16'hDEAD);
        #1;
        chk_cnt++;
        if (in_rdy !== 1'b1) $display("FAIL bad_rdy: got %b expected 1", in_rdy);
        else pass_cnt++;
        tick();
        drive(1'b0, 1'b0, 3'd0, 6'h00, 16'h0000);
        chk_cnt++;
        if (out_vld !== 5'b0 || drop_pulse !== 1'b1 || drop_cnt !== 8'd1)
            $display("FAIL bad_drop: got vld=%b pulse=%b cnt=%0d expected 0/1/1", out_vld, drop_pulse, drop_cnt);
        else pass_cnt++;
        tick();
        chk_cnt++;
        if (drop_pulse !== 1'b0) $display("FAIL bad_pulse_width: got %b expected 0", drop_pulse);
        else pass_cnt++;
    endtask

    task automatic test_saturation();
        in_vld2 = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            tick();
            chk_cnt++;
            if (drop_cnt2 !== 2'((k > 3) ? 3 : k)) $display("FAIL sat_cnt[%0d]: got %0d expected %0d", k, drop_cnt2, (k > 3) ? 3 : k);
            else pass_cnt++;
        end
        in_vld2 = 1'b0;
    endtask

    task automatic test_streaming();
        int sent = 0;
        int cyc  = 0;
        int acc  = 0;
        drive(1'b1, 1'b0, 3'($urandom_range(0, 4)), 6'($urandom), 16'($urandom));
        while (sent < 100 && cyc < 3000) begin
            out_rdy = 5'($urandom);
            tick();
            cyc++;
            if (mon_acc) begin
                sent++;
                drive(1'b1, 1'b0, 3'($urandom_range(0, 4)), 6'($urandom), 16'($urandom));
            end
        end
        chk_cnt++;
        if (sent != 100) $display("FAIL stream_sent: got %0d expected 100", sent);
        else pass_cnt++;
        out_rdy = 5'b11111;
        for (int c = 0; c < 20; c++) begin
            tick();
            if (mon_acc) acc++;
            drive(1'b1, 1'b0, 3'($urandom_range(0, 4)), 6'($urandom), 16'($urandom));
        end
        drive(1'b0, 1'b0, 3'd0, 6'h00, 16'h0000);
        chk_cnt++;
        if (acc != 20) $display("FAIL stream_full_rate: got %0d expected 20", acc);
        else pass_cnt++;
        tick(); tick(); tick();
        chk_cnt++;
        if ((sb_q[0].size() + sb_q[1].size() + sb_q[2].size() + sb_q[3].size() + sb_q[4].size()) != 0)
            $display("FAIL stream_loss: got %0d pending expected 0",
                     sb_q[0].size() + sb_q[1].size() + sb_q[2].size() + sb_q[3].size() + sb_q[4].size());
        else pass_cnt++;
    endtask

    task automatic test_reset_mid();
        out_rdy = 5'b00000;
        drive(1'b1, 1'b0, 3'd0, 6'h11, 16'h5A5A);
        tick();
        drive(1'b1, 1'b0, 3'd4, 6'h12, 16'hA5A5);
        tick();
        drive(1'b0, 1'b0, 3'd0, 6'h00, 16'h0000);
        mon_en = 1'b0;
        #1;
        rst_n = 1'b0;
        #1;
        chk_cnt++;
        if (out_vld !== 5'b0 || drop_cnt !== 8'd0 || out_data !== '0)
            $display("FAIL mid_reset: got vld=%b cnt=%0d expected 0/0", out_vld, drop_cnt);
        else pass_cnt++;
        for (int i = 0; i < N; i++) sb_q[i].delete();
        exp_drop_cnt   = 8'd0;
        exp_drop_pulse = 1'b0;
        @(posedge clk);
        #3;
        rst_n  = 1'b1;
        mon_en = 1'b1;
        out_rdy = 5'b11111;
        tick();
        drive(1'b1, 1'b0, 3'd4, 6'h2A, 16'hCAFE);
        tick();
        drive(1'b0, 1'b0, 3'd0, 6'h00, 16'h0000);
        chk_cnt++;
        if (out_vld !== 5'b10000 || out_data[4*DW +: DW] !== 16'hCAFE)
            $display("FAIL mid_after: got %b/%h expected 10000/cafe", out_vld, out_data[4*DW +: DW]);
        else pass_cnt++;
        tick();
    endtask

    initial begin
        rst_n   = 1'b0;
        in_vld2 = 1'b0;
        out_rdy = 5'b11111;
        drive(1'b0, 1'b0, 3'd0, 6'h00, 16'h0000);
        #3;
        test_reset();
        #9;
        rst_n  = 1'b1;
        mon_en = 1'b1;
        tick();
        test_unicast();
        test_backpressure();
        test_broadcast();
        test_bad_dest();
        test_saturation();
        test_streaming();
        test_reset_mid();
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
